// File: rtl/mpram_write_front.sv
// Write/read front end for the XOR multi-port RAM: zero-fills the array after reset,
// resolves same-address write collisions and forwards in-flight writes to reads.
module mpram_write_front #(
   parameter  int DATA_DEPTH = 128,
   parameter  int DATA_WIDTH = 64,
   parameter  int WPORTS_NUM = 4,
   parameter  int RPORTS_NUM = 4,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [WPORTS_NUM-1:0]                  wr_en_i,
   input  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  wr_addr_i,
   input  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  wr_data_i,
   input  logic [RPORTS_NUM-1:0]                  rd_en_i,
   input  logic [RPORTS_NUM-1:0][ADDR_WIDTH-1:0]  rd_addr_i,
   output logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  rd_data_o,
   output logic [RPORTS_NUM-1:0]                  rd_valid_o,
   output logic                                   ready_o,
   output logic [15:0]                            collision_cnt_o,
   output logic [WPORTS_NUM-1:0]                  ram_en_w_o,
   output logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  ram_waddr_o,
   output logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  ram_wdata_o,
   output logic [RPORTS_NUM-1:0]                  ram_en_r_o,
   output logic [RPORTS_NUM-1:0][ADDR_WIDTH-1:0]  ram_raddr_o,
   input  logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  ram_rdata_i
);

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

   state_t                                 state;
   logic [ADDR_WIDTH-1:0]                  init_cnt;

   logic [WPORTS_NUM-1:0]                  drop_vec;
   logic [15:0]                            drop_num;
   logic [16:0]                            coll_sum;

   logic [WPORTS_NUM-1:0]                  nxt_en;
   logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  nxt_addr;
   logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  nxt_data;

   logic [WPORTS_NUM-1:0]                  hist_en;
   logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]  hist_addr;
   logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]  hist_data;

   logic [RPORTS_NUM-1:0]                  fwd_hit;
   logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  fwd_data;
   logic [RPORTS_NUM-1:0]                  fwd_hit_q;
   logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  fwd_data_q;
   logic [RPORTS_NUM-1:0][DATA_WIDTH-1:0]  rd_hold;

   // A lower-numbered port loses to any higher-numbered port hitting the same address.
   always_comb begin
      drop_vec = '0;
      drop_num = '0;
      for (int i = 0; i < WPORTS_NUM; i++) begin
         for (int j = i + 1; j < WPORTS_NUM; j++) begin
            if (wr_en_i[i] && wr_en_i[j] && (wr_addr_i[i] == wr_addr_i[j])) begin
               drop_vec[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < WPORTS_NUM; i++) begin
         drop_num = drop_num + 16'(drop_vec[i]);
      end
      coll_sum = {1'b0, collision_cnt_o} + {1'b0, drop_num};
   end

   always_comb begin
      nxt_en   = '0;
      nxt_addr = '0;
      nxt_data = '0;
      if (state == ST_INIT) begin
         nxt_en[0]   = 1'b1;
         nxt_addr[0] = init_cnt;
      end else begin
         nxt_en   = wr_en_i & ~drop_vec;
         nxt_addr = wr_addr_i;
         nxt_data = wr_data_i;
      end
   end

   // Scan oldest to youngest so the most recent matching write overrides earlier ones.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int k = 0; k < RPORTS_NUM; k++) begin
         for (int i = 0; i < WPORTS_NUM; i++) begin
            if (hist_en[i] && (hist_addr[i] == rd_addr_i[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = hist_data[i];
            end
         end
         for (int i = 0; i < WPORTS_NUM; i++) begin
            if (ram_en_w_o[i] && (ram_waddr_o[i] == rd_addr_i[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = ram_wdata_o[i];
            end
         end
         for (int i = 0; i < WPORTS_NUM; i++) begin
            if (nxt_en[i] && (nxt_addr[i] == rd_addr_i[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = nxt_data[i];
            end
         end
      end
   end

   // RAM data only arrives in the response cycle, so the forwarding decision is carried one cycle.
   always_comb begin
      rd_data_o = rd_hold;
      for (int k = 0; k < RPORTS_NUM; k++) begin
         if (rd_valid_o[k]) begin
            rd_data_o[k] = fwd_hit_q[k] ? fwd_data_q[k] : ram_rdata_i[k];
         end
      end
   end

   assign ram_en_r_o  = ((state == ST_RUN) && !rst) ? rd_en_i : '0;
   assign ram_raddr_o = rd_addr_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_INIT;
         init_cnt        <= '0;
         ready_o         <= 1'b0;
         ram_en_w_o      <= '0;
         ram_waddr_o     <= '0;
         ram_wdata_o     <= '0;
         hist_en         <= '0;
         hist_addr       <= '0;
         hist_data       <= '0;
         collision_cnt_o <= '0;
         rd_valid_o      <= '0;
         fwd_hit_q       <= '0;
         fwd_data_q      <= '0;
         rd_hold         <= '0;
      end else begin
         ram_en_w_o  <= nxt_en;
         ram_waddr_o <= nxt_addr;
         ram_wdata_o <= nxt_data;
         hist_en     <= ram_en_w_o;
         hist_addr   <= ram_waddr_o;
         hist_data   <= ram_wdata_o;
         for (int k = 0; k < RPORTS_NUM; k++) begin
            if (rd_valid_o[k]) begin
               rd_hold[k] <= rd_data_o[k];
            end
         end
         case (state)
            ST_INIT: begin
               rd_valid_o <= '0;
               fwd_hit_q  <= '0;
               if (init_cnt == LAST_ADDR) begin
                  state   <= ST_RUN;
                  ready_o <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + ADDR_WIDTH'(1);
               end
            end
            ST_RUN: begin
               rd_valid_o      <= rd_en_i;
               fwd_hit_q       <= fwd_hit;
               fwd_data_q      <= fwd_data;
               collision_cnt_o <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_mpram_write_front.sv
// Bench for mpram_write_front: a delayed-write RAM model behind the DUT plus an
// architectural write-first memory model compared every cycle, and directed literal checks.
module tb_mpram_write_front;

   localparam int DEPTH = 128;
   localparam int DW    = 64;
   localparam int WP    = 4;
   localparam int RP    = 4;
   localparam int AW    = 7;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [WP-1:0]          wr_en_i;
   logic [WP-1:0][AW-1:0]  wr_addr_i;
   logic [WP-1:0][DW-1:0]  wr_data_i;
   logic [RP-1:0]          rd_en_i;
   logic [RP-1:0][AW-1:0]  rd_addr_i;
   logic [RP-1:0][DW-1:0]  rd_data_o;
   logic [RP-1:0]          rd_valid_o;
   logic                   ready_o;
   logic [15:0]            collision_cnt_o;
   logic [WP-1:0]          ram_en_w_o;
   logic [WP-1:0][AW-1:0]  ram_waddr_o;
   logic [WP-1:0][DW-1:0]  ram_wdata_o;
   logic [RP-1:0]          ram_en_r_o;
   logic [RP-1:0][AW-1:0]  ram_raddr_o;
   logic [RP-1:0][DW-1:0]  ram_rdata_i;

   int tests_run    = 0;
   int tests_failed = 0;

   mpram_write_front #(
      .DATA_DEPTH(DEPTH),
      .DATA_WIDTH(DW),
      .WPORTS_NUM(WP),
      .RPORTS_NUM(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_en_i(wr_en_i),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i),
      .rd_en_i(rd_en_i),
      .rd_addr_i(rd_addr_i),
      .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o),
      .ready_o(ready_o),
      .collision_cnt_o(collision_cnt_o),
      .ram_en_w_o(ram_en_w_o),
      .ram_waddr_o(ram_waddr_o),
      .ram_wdata_o(ram_wdata_o),
      .ram_en_r_o(ram_en_r_o),
      .ram_raddr_o(ram_raddr_o),
      .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk = ~clk;

   // RAM stand-in: one internal register stage before the array write, registered reads.
   logic [DW-1:0]          bram [DEPTH];
   logic [WP-1:0]          p_en;
   logic [WP-1:0][AW-1:0]  p_addr;
   logic [WP-1:0][DW-1:0]  p_data;
   bit                     seeded = 1'b0;

   always @(posedge clk) begin
      if (!seeded) begin
         for (int a = 0; a < DEPTH; a++) bram[a] <= 64'hBAD0_0000_0000_0000 | DW'(a);
         p_en   <= '0;
         seeded <= 1'b1;
      end else begin
         p_en   <= ram_en_w_o;
         p_addr <= ram_waddr_o;
         p_data <= ram_wdata_o;
         for (int i = 0; i < WP; i++) if (p_en[i]) bram[p_addr[i]] <= p_data[i];
         for (int k = 0; k < RP; k++) if (ram_en_r_o[k]) ram_rdata_i[k] <= bram[ram_raddr_o[k]];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Architectural model: memory reads as all-zero after the sweep, writes apply in port order.
   logic [DW-1:0]          m_mem [DEPTH];
   bit                     m_live = 1'b0;
   int                     m_init_left;
   int                     m_cnt;
   int                     winner [int];
   int                     n_en;
   logic [WP-1:0]          e_en_w;
   logic [WP-1:0][AW-1:0]  e_waddr;
   logic [WP-1:0][DW-1:0]  e_wdata;
   logic                   e_ready;
   logic [RP-1:0]          e_valid;
   logic [RP-1:0][DW-1:0]  e_rd;
   int                     e_coll;

   always @(posedge clk) begin
      if (rst) begin
         m_live      = 1'b1;
         m_init_left = DEPTH;
         m_cnt       = 0;
         foreach (m_mem[a]) m_mem[a] = '0;
         e_en_w  = '0;
         e_ready = 1'b0;
         e_valid = '0;
         e_rd    = '0;
         e_coll  = 0;
      end else if (m_live) begin
         e_en_w  = '0;
         e_valid = '0;
         if (m_init_left > 0) begin
            e_en_w[0]  = 1'b1;
            e_waddr[0] = AW'(m_cnt);
            e_wdata[0] = '0;
            m_cnt++;
            m_init_left--;
            e_ready = (m_init_left == 0);
         end else begin
            winner.delete();
            n_en = 0;
            for (int i = 0; i < WP; i++) begin
               if (wr_en_i[i]) begin
                  n_en++;
                  winner[int'(wr_addr_i[i])] = i;
               end
            end
            for (int i = 0; i < WP; i++) begin
               if (wr_en_i[i] && winner[int'(wr_addr_i[i])] == i) begin
                  e_en_w[i]  = 1'b1;
                  e_waddr[i] = wr_addr_i[i];
                  e_wdata[i] = wr_data_i[i];
                  m_mem[wr_addr_i[i]] = wr_data_i[i];
               end
            end
            e_coll = e_coll + n_en - winner.num();
            if (e_coll > 65535) e_coll = 65535;
            for (int k = 0; k < RP; k++) begin
               if (rd_en_i[k]) begin
                  e_valid[k] = 1'b1;
                  e_rd[k]    = m_mem[rd_addr_i[k]];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         checkOutput("ready", ready_o, e_ready);
         checkOutput("rd_valid", rd_valid_o, e_valid);
         checkOutput("coll_cnt", collision_cnt_o, e_coll);
         checkOutput("ram_en_w", ram_en_w_o, e_en_w);
         checkOutput("ram_en_r", ram_en_r_o, (e_ready && !rst) ? rd_en_i : '0);
         for (int i = 0; i < WP; i++) begin
            if (e_en_w[i]) begin
               checkOutput($sformatf("ram_waddr%0d", i), ram_waddr_o[i], e_waddr[i]);
               checkOutput($sformatf("ram_wdata%0d", i), ram_wdata_o[i], e_wdata[i]);
            end
         end
         for (int k = 0; k < RP; k++) begin
            checkOutput($sformatf("rd_data%0d", k), rd_data_o[k], e_rd[k]);
            if (e_ready && !rst && rd_en_i[k]) begin
               checkOutput($sformatf("ram_raddr%0d", k), ram_raddr_o[k], rd_addr_i[k]);
            end
         end
      end
   end

   task automatic clearInputs();
      wr_en_i   = '0;
      wr_addr_i = '0;
      wr_data_i = '0;
      rd_en_i   = '0;
      rd_addr_i = '0;
   endtask

   task automatic setWrite(input int p, input int a, input logic [DW-1:0] d);
      wr_en_i[p]   = 1'b1;
      wr_addr_i[p] = AW'(a);
      wr_data_i[p] = d;
   endtask

   task automatic setRead(input int k, input int a);
      rd_en_i[k]   = 1'b1;
      rd_addr_i[k] = AW'(a);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Sweep with junk traffic on every port, which must be ignored.
   task automatic doSweep();
      for (int c = 0; c < DEPTH; c++) begin
         wr_en_i = '1;
         rd_en_i = '1;
         for (int i = 0; i < WP; i++) begin
            wr_addr_i[i] = AW'($urandom_range(0, DEPTH - 1));
            wr_data_i[i] = {$urandom, $urandom};
         end
         for (int k = 0; k < RP; k++) rd_addr_i[k] = AW'($urandom_range(0, DEPTH - 1));
         applyStimulus();
         checkOutput("sweep_en_w", ram_en_w_o, 4'b0001);
         checkOutput("sweep_addr", ram_waddr_o[0], c);
         checkOutput("sweep_data", ram_wdata_o[0], 0);
         checkOutput("sweep_ready", ready_o, (c == DEPTH - 1));
         checkOutput("sweep_valid", rd_valid_o, 0);
      end
      clearInputs();
   endtask

   initial begin
      logic [DW-1:0] last_d;
      rst = 1'b1;
      clearInputs();
      applyStimulus();
      rst = 1'b0;
      checkOutput("reset_ready", ready_o, 0);
      checkOutput("reset_en_w", ram_en_w_o, 0);
      checkOutput("reset_valid", rd_valid_o, 0);
      checkOutput("reset_coll", collision_cnt_o, 0);
      checkOutput("reset_rd_data0", rd_data_o[0], 0);

      doSweep();

      setRead(0, 5);
      applyStimulus();
      checkOutput("init_read5_valid", rd_valid_o[0], 1);
      checkOutput("init_read5_data", rd_data_o[0], 0);

      clearInputs();
      setWrite(0, 7, 64'hAAAA_AAAA_AAAA_AAAA);
      setWrite(2, 7, 64'hBBBB_BBBB_BBBB_BBBB);
      applyStimulus();
      checkOutput("coll_en_w", ram_en_w_o, 4'b0100);
      checkOutput("coll_addr2", ram_waddr_o[2], 7);
      checkOutput("coll_data2", ram_wdata_o[2], 64'hBBBB_BBBB_BBBB_BBBB);
      checkOutput("coll_cnt1", collision_cnt_o, 1);
      clearInputs();
      repeat (3) applyStimulus();
      setRead(1, 7);
      applyStimulus();
      checkOutput("coll_read7", rd_data_o[1], 64'hBBBB_BBBB_BBBB_BBBB);

      clearInputs();
      setWrite(1, 3, 64'hDEAD);
      setRead(0, 3);
      applyStimulus();
      checkOutput("same_cycle_valid", rd_valid_o[0], 1);
      checkOutput("same_cycle_data", rd_data_o[0], 64'hDEAD);

      clearInputs();
      setWrite(0, 9, 64'h11);
      setRead(2, 9);
      applyStimulus();
      checkOutput("age_t0", rd_data_o[2], 64'h11);
      clearInputs();
      setWrite(3, 9, 64'h22);
      setRead(2, 9);
      applyStimulus();
      checkOutput("age_t1", rd_data_o[2], 64'h22);
      for (int n = 2; n <= 4; n++) begin
         clearInputs();
         setRead(2, 9);
         applyStimulus();
         checkOutput($sformatf("age_t%0d", n), rd_data_o[2], 64'h22);
      end
      clearInputs();
      rd_addr_i[2] = AW'(10);
      applyStimulus();
      checkOutput("hold_data", rd_data_o[2], 64'h22);
      checkOutput("hold_valid", rd_valid_o[2], 0);
      checkOutput("coll_unchanged", collision_cnt_o, 1);

      last_d = '0;
      for (int i = 0; i < 23334; i++) begin
         clearInputs();
         for (int p = 0; p < WP; p++) setWrite(p, 20, (DW'(p) << 32) | DW'(i));
         last_d = (DW'(3) << 32) | DW'(i);
         applyStimulus();
         if (i == 999) checkOutput("coll_cnt3001", collision_cnt_o, 3001);
      end
      checkOutput("coll_saturated", collision_cnt_o, 16'hFFFF);
      checkOutput("model_coll_saturated", e_coll, 65535);
      clearInputs();
      repeat (3) applyStimulus();
      setRead(3, 20);
      applyStimulus();
      checkOutput("sat_read20", rd_data_o[3], last_d);

      clearInputs();
      setWrite(0, 11, 64'h5555);
      setWrite(1, 12, 64'h6666);
      applyStimulus();
      checkOutput("pending_en_w", ram_en_w_o, 4'b0011);
      rst = 1'b1;
      applyStimulus();
      checkOutput("midrst_en_w", ram_en_w_o, 0);
      checkOutput("midrst_ready", ready_o, 0);
      checkOutput("midrst_valid", rd_valid_o, 0);
      checkOutput("midrst_coll", collision_cnt_o, 0);
      rst = 1'b0;
      clearInputs();
      doSweep();
      setRead(0, 11);
      setRead(1, 12);
      setRead(2, 20);
      setRead(3, 9);
      applyStimulus();
      for (int k = 0; k < RP; k++) begin
         checkOutput($sformatf("post_rst_read%0d", k), rd_data_o[k], 0);
      end
      clearInputs();
      repeat (2) applyStimulus();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mpram_write_front.md
Name: mpram_write_front

Overview:
- Front-end stage directly upstream of the XOR-based multi-port RAM.
- Owns all RAM write/read port signals and fills the RAM with zeros after reset, since the RAM array has no reset.
- Resolves same-cycle write-address collisions between ports.
- Forwards in-flight write data to reads so that the pipeline sees write-first semantics across the RAM's internal write delay.

Parameters:
- DATA_DEPTH, 128, number of RAM entries.
- DATA_WIDTH, 64, bits per entry.
- WPORTS_NUM, 4, write ports; must be at least 2.
- RPORTS_NUM, 4, read ports; must be at least 1.
- ADDR_WIDTH, $clog2(DATA_DEPTH), derived; not overridable.

Ports:
- clk  in  1  single clock for the block and for all RAM ports (common_clock).
- rst  in  1  synchronous reset, active-high.
- wr_en_i  in  WPORTS_NUM  per-port write request.
- wr_addr_i  in  WPORTS_NUM x ADDR_WIDTH  write addresses.
- wr_data_i  in  WPORTS_NUM x DATA_WIDTH  write data.
- rd_en_i  in  RPORTS_NUM  per-port read request.
- rd_addr_i  in  RPORTS_NUM x ADDR_WIDTH  read addresses.
- rd_data_o  out  RPORTS_NUM x DATA_WIDTH  read data, 1 cycle after request.
- rd_valid_o  out  RPORTS_NUM  qualifies rd_data_o.
- ready_o  out  1  high once the init sweep has completed.
- collision_cnt_o  out  16  saturating count of suppressed writes.
- ram_en_w_o  out  WPORTS_NUM  to RAM en_w_i; RAM we_i is tied all-ones by the parent.
- ram_waddr_o  out  WPORTS_NUM x ADDR_WIDTH  to RAM waddr_i.
- ram_wdata_o  out  WPORTS_NUM x DATA_WIDTH  to RAM data_i.
- ram_en_r_o  out  RPORTS_NUM  to RAM en_r_i.
- ram_raddr_o  out  RPORTS_NUM x ADDR_WIDTH  to RAM raddr_i.
- ram_rdata_i  in  RPORTS_NUM x DATA_WIDTH  from RAM data_o, valid 1 cycle after ram_raddr_o.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
- Reset values: ready_o=0, rd_valid_o=0, ram_en_w_o=0, ram_en_r_o=0, collision_cnt_o=0, rd_data_o=0. Init counter=0, forwarding history cleared, FSM=INIT.
- FSM state INIT:
  - Each cycle, port 0 writes 0 to address cnt; all other write ports are disabled; cnt increments.
  - wr_en_i and rd_en_i are ignored; rd_valid_o=0; ready_o=0.
  - On the cycle cnt==DATA_DEPTH-1 is issued, go to RUN.
  - ready_o rises on the first RUN cycle, DATA_DEPTH cycles after rst deasserts.
- FSM state RUN, write path:
  - Accepted writes are registered: ram_en_w_o/ram_waddr_o/ram_wdata_o at t+1 mirror port requests at t.
  - Collision: if wr_en_i[i] and wr_en_i[j] are both set with i<j and equal addresses, port j wins. Port i is dropped (ram_en_w_o[i]=0 at t+1).
  - collision_cnt_o increments by the number of dropped ports that cycle and saturates at 16'hFFFF.
- FSM state RUN, read path:
  - ram_raddr_o = rd_addr_i and ram_en_r_o = rd_en_i, both combinational.
  - rd_valid_o[k] at t+1 = rd_en_i[k] at t.
- Forwarding:
  - A write accepted at cycle w is not guaranteed readable from the RAM until a read issued at w+3 (1 front register + 1 RAM internal delay + RAM write).
  - rd_data_o[k] for a read at t equals the data of the youngest surviving write to the same address accepted in cycles t, t-1 or t-2. This includes same-cycle writes (write_first).
  - Only if no such write exists does rd_data_o take ram_rdata_i[k].
  - Within one cycle, at most one surviving write exists per address, so no intra-cycle tie is possible.
- When rd_en_i[k]=0, rd_data_o[k] holds its previous value.
- Reset mid-operation: the in-progress sweep or RUN traffic is abandoned and the FSM returns to INIT at cnt=0. History is cleared and the full sweep is re-run. Writes pending in the front register are discarded (ram_en_w_o=0 the next cycle).
- Address wrap: the cnt comparison uses DATA_DEPTH-1, which is correct for non-power-of-two depths; cnt never exceeds DATA_DEPTH-1.

Test Plan:
- Init sweep: rst 1 cycle, DATA_DEPTH=128. Require ram_en_w_o[0]=1 with addresses 0..127 and data 0, other ports 0, ready_o high at cycle 128. A read of addr 5 then returns 0.
- Collision: port0 and port2 write addr 7 with A and B in the same cycle. Require ram_en_w_o[0]=0 and ram_en_w_o[2]=1 at t+1, collision_cnt_o=1, and a later read of 7 returns B.
- Same-cycle forward: port1 writes 0xDEAD to addr 3 while rd port0 reads addr 3 in the same cycle. Require rd_data_o[0]=0xDEAD and rd_valid_o[0]=1 the next cycle.
- Aged forward: write 0x11 to addr 9 at t, write 0x22 to addr 9 at t+1, then read addr 9 at t+1, t+2, t+3 and t+4. Require 0x22 on each, taken from forwarding at t+1..t+3 and from RAM at t+4.
- Saturation: force 70000 dropped writes. Require collision_cnt_o to stick at 16'hFFFF.
- Reset mid-RUN: assert rst with writes pending. Require no RAM write on the following cycle, ready_o=0, a restarted sweep at addr 0, and reads after the sweep return 0.
